// File: rtl/counter_pkg.sv
// Shared constants for the 4-bit loadable counter and its reload controller.
package counter_pkg;

   localparam int              CNT_WIDTH    = 4;
   localparam logic [3:0]      TERMINAL_DEF = 4'hF;

   localparam logic [0:0]      IDLE = 1'b0;
   localparam logic [0:0]      RUN  = 1'b1;

endpackage

// File: rtl/reload_fifo.sv
// First-word fall-through FIFO holding queued reload values; head reads 0 when empty.
module reload_fifo #(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push, do_pop;

   // Extra wrap bit on each pointer distinguishes full from empty.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign level = level_q;

   always_comb begin
      do_push  = push && !full && !flush;
      do_pop   = pop && !empty && !flush;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/counter_reload_ctrl.sv
// Load sequencer: replaces each terminal count of the up counter with the next queued value.
module counter_reload_ctrl
   import counter_pkg::*;
#(
   parameter int               WIDTH    = CNT_WIDTH,
   parameter int               DEPTH    = 4,
   parameter logic [WIDTH-1:0] TERMINAL = TERMINAL_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         count,
   output logic                     load,
   output logic [WIDTH-1:0]         d_in,
   output logic                     tc_pulse,
   output logic                     underrun,
   output logic [$clog2(DEPTH):0]   level
);

   logic [0:0]       state_q, state_d;
   logic             tc_q, tc_d;
   logic             underrun_q, underrun_d;
   logic             full, empty, at_term;
   logic [WIDTH-1:0] head;

   reload_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (in_valid && !full),
      .push_data (in_data),
      .pop       (load),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign at_term  = (count == TERMINAL);
   assign in_ready = !full;
   assign d_in     = head;
   assign tc_pulse = tc_q;
   assign underrun = underrun_q;

   always_comb begin
      state_d    = state_q;
      load       = 1'b0;
      tc_d       = (state_q == RUN) && at_term;
      underrun_d = underrun_q | (tc_d && empty);
      if (flush) begin
         state_d = IDLE;
      end else if (state_q == IDLE) begin
         if (!empty) begin
            load    = 1'b1;
            state_d = RUN;
         end
      end else if (at_term) begin
         // Empty at terminal: let the counter wrap and wait for new data.
         if (!empty) load = 1'b1;
         else        state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tc_q       <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tc_q       <= tc_d;
         underrun_q <= underrun_d;
      end
   end

endmodule

// File: tb/tb_counter_reload_ctrl.sv
// Bench for counter_reload_ctrl: vector table, directed corner sequences, random vs queue model.
module tb_counter_reload_ctrl;

   localparam logic [3:0] TERM = 4'hF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] in_data = 4'h0;
   logic       in_ready;
   logic [3:0] count;
   logic       load;
   logic [3:0] d_in;
   logic       tc_pulse;
   logic       underrun;
   logic [2:0] level;

   logic       cnt_auto = 1'b0;
   logic [3:0] cnt_man = 4'h0;
   logic [3:0] cnt_model = 4'h0;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state
   logic [3:0] mq[$];
   bit         m_run = 0;
   bit         m_und = 0;
   bit         m_tc  = 0;

   assign count = cnt_auto ? cnt_model : cnt_man;

   always #5 clk = ~clk;

   counter_reload_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .count    (count),
      .load     (load),
      .d_in     (d_in),
      .tc_pulse (tc_pulse),
      .underrun (underrun),
      .level    (level)
   );

   // Counter attached to the controller's load/d_in.
   always @(posedge clk) cnt_model <= load ? d_in : cnt_model + 4'd1;

   always @(posedge clk) begin
      bit pe, te;
      if (rst) begin
         mq.delete();
         m_run = 0;
         m_und = 0;
         m_tc  = 0;
      end else begin
         te   = (count == TERM);
         m_tc = m_run && te;
         if (m_run && te && mq.size() == 0) m_und = 1;
         if (flush) begin
            mq.delete();
            m_run = 0;
         end else begin
            pe = in_valid && (mq.size() < 4);
            if (mq.size() > 0 && (!m_run || te)) begin
               void'(mq.pop_front());
               m_run = 1;
            end else if (m_run && te) begin
               m_run = 0;
            end
            if (pe) mq.push_back(in_data);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      logic ml;
      ml = !flush && mq.size() > 0 && (!m_run || count == TERM);
      chk("m_load", load, ml);
      chk("m_d_in", d_in, (mq.size() > 0) ? mq[0] : 4'h0);
      chk("m_in_ready", in_ready, mq.size() < 4);
      chk("m_level", level, mq.size());
      chk("m_tc_pulse", tc_pulse, m_tc);
      chk("m_underrun", underrun, m_und);
   endtask

   task automatic set_in(input logic r, input logic f, input logic v,
                         input logic [3:0] d, input logic [3:0] c);
      @(negedge clk);
      rst = r; flush = f; in_valid = v; in_data = d; cnt_man = c;
      #1 cmp_model();
   endtask

   task automatic cyc(input logic r, input logic f, input logic v,
                      input logic [3:0] d, input logic [3:0] c);
      set_in(r, f, v, d, c);
      @(posedge clk);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
   endtask

   typedef struct {
      logic f, v; logic [3:0] d, c;
      logic ld; logic [3:0] di; logic rdy; logic [2:0] lv; logic tc, ur;
   } vec_t;

   vec_t tbl[7];
   logic [3:0] exp_seq[$];

   initial begin
      // Reset, push 3, load it, hit terminal with empty FIFO.
      tbl[0] = '{0,0,4'h0,4'h0, 0,4'h0,1,3'd0,0,0};
      tbl[1] = '{0,1,4'h3,4'h0, 0,4'h0,1,3'd0,0,0};
      tbl[2] = '{0,0,4'h0,4'h0, 1,4'h3,1,3'd1,0,0};
      tbl[3] = '{0,0,4'h0,4'h3, 0,4'h0,1,3'd0,0,0};
      tbl[4] = '{0,0,4'h0,4'hF, 0,4'h0,1,3'd0,0,0};
      tbl[5] = '{0,0,4'h0,4'hF, 0,4'h0,1,3'd0,1,1};
      tbl[6] = '{0,0,4'h0,4'h0, 0,4'h0,1,3'd0,0,1};

      do_reset();
      foreach (tbl[i]) begin
         set_in(0, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].c);
         chk($sformatf("tbl%0d_load", i), load, tbl[i].ld);
         chk($sformatf("tbl%0d_d_in", i), d_in, tbl[i].di);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].rdy);
         chk($sformatf("tbl%0d_level", i), level, tbl[i].lv);
         chk($sformatf("tbl%0d_tc", i), tc_pulse, tbl[i].tc);
         chk($sformatf("tbl%0d_underrun", i), underrun, tbl[i].ur);
         @(posedge clk);
      end

      // Reload chain with the counter attached: 3..F, A..F, C..F, then wrap.
      do_reset();
      cnt_auto = 1'b1;
      for (int v = 3; v <= 15; v++) exp_seq.push_back(4'(v));
      for (int v = 10; v <= 15; v++) exp_seq.push_back(4'(v));
      for (int v = 12; v <= 15; v++) exp_seq.push_back(4'(v));
      exp_seq.push_back(4'h0);
      exp_seq.push_back(4'h1);
      cyc(0, 0, 1, 4'h3, 0);
      cyc(0, 0, 1, 4'hA, 0);
      for (int i = 0; i < exp_seq.size(); i++) begin
         set_in(0, 0, i == 0, 4'hC, 0);
         chk($sformatf("chain_count%0d", i), count, exp_seq[i]);
         chk($sformatf("chain_tc%0d", i), tc_pulse, i > 0 && exp_seq[i-1] == 4'hF);
         chk($sformatf("chain_underrun%0d", i), underrun, i >= 23);
         @(posedge clk);
      end
      cnt_auto = 1'b0;

      // Back-pressure: fill during RUN, fifth push dropped.
      do_reset();
      cyc(0, 0, 1, 4'h1, 4'h0);
      cyc(0, 0, 0, 4'h0, 4'h0);
      for (int k = 2; k <= 5; k++) cyc(0, 0, 1, 4'(k), 4'h5);
      set_in(0, 0, 1, 4'h7, 4'h5);
      chk("full_level", level, 4);
      chk("full_in_ready", in_ready, 0);
      @(posedge clk);
      for (int k = 2; k <= 5; k++) begin
         set_in(0, 0, 0, 4'h0, 4'hF);
         chk("drain_load", load, 1);
         chk("drain_d_in", d_in, 4'(k));
         @(posedge clk);
      end
      set_in(0, 0, 0, 4'h0, 4'hF);
      chk("drain_no7", load, 0);
      @(posedge clk);

      // Push and pop in the same cycle with one entry held.
      do_reset();
      cyc(0, 0, 1, 4'h1, 4'h0);
      cyc(0, 0, 1, 4'h8, 4'h0);
      set_in(0, 0, 1, 4'h9, 4'hF);
      chk("pp_load", load, 1);
      chk("pp_d_in", d_in, 4'h8);
      @(posedge clk);
      set_in(0, 0, 0, 4'h0, 4'h0);
      chk("pp_level", level, 1);
      @(posedge clk);
      set_in(0, 0, 0, 4'h0, 4'hF);
      chk("pp_next", d_in, 4'h9);
      @(posedge clk);

      // Flush in RUN with level 3 at terminal, push offered and discarded.
      do_reset();
      cyc(0, 0, 1, 4'h1, 4'h0);
      cyc(0, 0, 1, 4'h2, 4'h0);
      cyc(0, 0, 1, 4'h3, 4'h0);
      cyc(0, 0, 1, 4'h4, 4'h0);
      set_in(0, 1, 1, 4'h6, 4'hF);
      chk("fl_level_before", level, 3);
      chk("fl_load", load, 0);
      @(posedge clk);
      set_in(0, 0, 0, 4'h0, 4'hF);
      chk("fl_level", level, 0);
      chk("fl_underrun", underrun, 0);
      @(posedge clk);
      set_in(0, 0, 0, 4'h0, 4'h0);
      chk("fl_idle_no_underrun", underrun, 0);
      @(posedge clk);

      // Reset mid-operation with two entries queued.
      cyc(0, 0, 1, 4'h1, 4'h0);
      cyc(0, 0, 1, 4'h2, 4'h0);
      cyc(0, 0, 1, 4'h3, 4'h0);
      cyc(1, 0, 0, 4'h0, 4'h0);
      set_in(0, 0, 0, 4'h0, 4'h0);
      chk("rst_level", level, 0);
      chk("rst_load", load, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge clk);
      cyc(0, 0, 1, 4'h5, 4'h0);
      set_in(0, 0, 0, 4'h0, 4'h0);
      chk("rst_reload_load", load, 1);
      chk("rst_reload_d_in", d_in, 4'h5);
      @(posedge clk);

      // Random traffic against the queue model.
      for (int i = 0; i < 500; i++) begin
         cyc($urandom_range(0, 63) == 0,
             $urandom_range(0, 15) == 0,
             $urandom_range(0, 1) == 1,
             4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
